// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : I-cache miss-refill sequencer on the AHB master side. Arbitrates
//            between a demand-miss and a prefetch requester (demand wins),
//            issues one AHB WRAP4 read burst per grant (critical word first),
//            assembles the four returned words into a line and presents it to
//            the cache array as a one-cycle fill strobe.
// Optional : `define REFILL_CWF_EN adds crit_valid / crit_data, a one-cycle
//            early forward of the critical word for demand refills.
// Ports    :
//   clk, rstn                 clock, asynchronous active-low reset
//   dm_req/dm_addr/dm_ack     demand-miss request (level) and grant pulse
//   pf_req/pf_addr/pf_ack     prefetch request (level) and grant pulse
//   haddr/htrans/hburst       AHB address phase outputs
//   hwrite/hsize              AHB constants (read, word)
//   hready/hresp/hrdata       AHB slave response
//   fill_valid/fill_addr      one-cycle line write strobe, line-aligned addr
//   fill_data/fill_is_pf      assembled line, prefetch origin flag
//   refill_err                one-cycle pulse when a burst is aborted
//   busy                      high from grant until return to idle
//   crit_valid/crit_data      (REFILL_CWF_EN only) early critical word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  dm_req,
   input  logic [ADDR_W-1:0]     dm_addr,
   output logic                  dm_ack,
   input  logic                  pf_req,
   input  logic [ADDR_W-1:0]     pf_addr,
   output logic                  pf_ack,
   output logic [ADDR_W-1:0]     haddr,
   output logic [1:0]            htrans,
   output logic [2:0]            hburst,
   output logic                  hwrite,
   output logic [2:0]            hsize,
   input  logic                  hready,
   input  logic                  hresp,
   input  logic [DATA_W-1:0]     hrdata,
   output logic                  fill_valid,
   output logic [ADDR_W-1:0]     fill_addr,
   output logic [4*DATA_W-1:0]   fill_data,
   output logic                  fill_is_pf,
   output logic                  refill_err,
   output logic                  busy
`ifdef REFILL_CWF_EN
   ,
   output logic                  crit_valid,
   output logic [DATA_W-1:0]     crit_data
`endif
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_FILL = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t                state, state_nxt;

   logic [ADDR_W-1:4]     line_base;   // line address of the current burst
   logic                  src;         // 1: prefetch, 0: demand
   logic [1:0]            acnt;        // address beats accepted so far
   logic [1:0]            dcnt;        // data beats captured so far
   logic                  dp_valid;    // a data phase is outstanding
   logic [1:0]            dp_slot;     // line slot of the outstanding data phase
   logic [4*DATA_W-1:0]   line_q;

   logic                  in_burst;
   logic                  capture;
   logic                  err_hit;
   logic                  grant;

   // Low address bits are forced to zero on grant and never observed.
   logic                  unused_addr_lsbs;
   assign unused_addr_lsbs = ^{dm_addr[1:0], pf_addr[1:0]};

   assign in_burst = (state == S_ADDR) || (state == S_DATA);
   // hready high closes the outstanding data phase (and, in S_ADDR, the
   // current address phase at the same time, since the two overlap).
   assign capture  = in_burst && dp_valid && hready;
   // First cycle of a two-cycle ERROR response.
   assign err_hit  = in_burst && dp_valid && !hready && hresp;
   assign grant    = dm_ack || pf_ack;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Next state and grant decode
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      dm_ack    = 1'b0;
      pf_ack    = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by rstn so no grant pulse escapes while in reset.
            if (rstn && dm_req) begin
               dm_ack    = 1'b1;
               state_nxt = S_ADDR;
            end else if (rstn && pf_req) begin
               pf_ack    = 1'b1;
               state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            if (err_hit)                      state_nxt = S_ERR;
            else if (hready && acnt == 2'd3)  state_nxt = S_DATA;
         end
         S_DATA: begin
            if (err_hit)                        state_nxt = S_ERR;
            else if (capture && dcnt == 2'd3)   state_nxt = S_FILL;
         end
         S_FILL:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Address phase, beat tracking and line assembly
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         haddr     <= '0;
         htrans    <= HTRANS_IDLE;
         hburst    <= HBURST_SINGLE;
         line_base <= '0;
         src       <= 1'b0;
         acnt      <= 2'd0;
         dcnt      <= 2'd0;
         dp_valid  <= 1'b0;
         dp_slot   <= 2'd0;
         line_q    <= '0;
      end else if (state == S_IDLE) begin
         if (grant) begin
            haddr     <= dm_ack ? {dm_addr[ADDR_W-1:2], 2'b00}
                                : {pf_addr[ADDR_W-1:2], 2'b00};
            line_base <= dm_ack ? dm_addr[ADDR_W-1:4] : pf_addr[ADDR_W-1:4];
            src       <= pf_ack;
            htrans    <= HTRANS_NONSEQ;
            hburst    <= HBURST_WRAP4;
            acnt      <= 2'd0;
            dcnt      <= 2'd0;
            dp_valid  <= 1'b0;
         end
      end else if (in_burst) begin
         if (err_hit) begin
            // Cancel the remaining beats; the line is simply never filled.
            htrans   <= HTRANS_IDLE;
            hburst   <= HBURST_SINGLE;
            dp_valid <= 1'b0;
         end else if (hready) begin
            if (capture) begin
               line_q[dp_slot*DATA_W +: DATA_W] <= hrdata;
               dcnt <= dcnt + 2'd1;
            end
            // The address accepted now owns the next data phase.
            dp_valid <= (state == S_ADDR);
            dp_slot  <= haddr[3:2];
            if (state == S_ADDR) begin
               if (acnt == 2'd3) begin
                  htrans <= HTRANS_IDLE;
                  hburst <= HBURST_SINGLE;
               end else begin
                  htrans <= HTRANS_SEQ;
                  // Wrap inside the 16-byte line; upper bits never change.
                  haddr  <= {haddr[ADDR_W-1:4], haddr[3:2] + 2'd1, 2'b00};
                  acnt   <= acnt + 2'd1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign hwrite     = 1'b0;
   assign hsize      = 3'b010;
   assign fill_valid = (state == S_FILL);
   assign fill_addr  = {line_base, 4'h0};
   assign fill_data  = line_q;
   assign fill_is_pf = (state == S_FILL) && src;
   assign refill_err = (state == S_ERR);
   assign busy       = (state != S_IDLE) || grant;

`ifdef REFILL_CWF_EN
   // The first capture of a burst is always the critical word.
   assign crit_valid = capture && (dcnt == 2'd0) && !src;
   assign crit_data  = hrdata;
`else
   // No early forward: the demand requester waits for fill_valid.
`endif

endmodule

`default_nettype wire
